bias_loader: RTL

- Write-side front end for the per-layer bias buffer.
- Accepts 128-bit bias beats from the DMA AXI-Stream and issues a one-cycle store clear before each load.
- Converts accepted beats into the buffer's sequential wr_en/wr_data write stream, two beats per 8-channel group.
- Reports completion, loaded group count and framing errors to the layer controller.

---
 rtl/bias_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bias_loader.sv
// rtl/bias_loader.sv - write-side front end for the per-layer bias buffer
//
// Accepts 128-bit bias beats from the DMA stream, pulses a one-cycle store
// clear before each load, and forwards accepted beats as a sequential
// wr_en/wr_data write stream (two beats per 8-channel group).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num_groups   load request and group count (sampled when busy=0)
//   s_axis_*            incoming bias beats (tdata/tvalid/tlast/tready)
//   store_clr           one-cycle buffer write-pointer reset
//   wr_en, wr_data      buffer write stream
//   busy, done          load in progress / one-cycle completion pulse
//   loaded_groups       complete groups written by the last load
//   err_cfg, err_early_last, err_no_last   sticky framing/config errors
//   checksum            (only with BIAS_LOADER_CHECKSUM_EN) lane sum mod 2^32
//
// Optional feature macro: BIAS_LOADER_CHECKSUM_EN

module bias_loader #(
    parameter int MAX_DEPTH   = 256,
    parameter int GROUP_WIDTH = $clog2(MAX_DEPTH/2) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [GROUP_WIDTH-1:0] num_groups,
    input  logic [127:0]           s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic                   store_clr,
    output logic                   wr_en,
    output logic [127:0]           wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [GROUP_WIDTH-1:0] loaded_groups,
    output logic                   err_cfg,
    output logic                   err_early_last,
    output logic                   err_no_last
`ifdef BIAS_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);

    localparam int                     CNT_WIDTH  = GROUP_WIDTH + 1;
    localparam logic [GROUP_WIDTH-1:0] MAX_GROUPS = GROUP_WIDTH'(MAX_DEPTH / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 state;
    logic [GROUP_WIDTH-1:0] groups_r;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [CNT_WIDTH-1:0]   beat_target;
    logic [CNT_WIDTH-1:0]   beat_next;
    logic                   handshake;
    logic                   final_beat;
    logic                   cfg_bad;
    logic                   start_ok;

    // Two beats per group, so the target is simply the group count shifted.
    assign beat_target = {groups_r, 1'b0};
    assign beat_next   = beat_cnt + CNT_WIDTH'(1);
    assign handshake   = s_axis_tvalid & s_axis_tready;
    assign final_beat  = (beat_next == beat_target);
    assign cfg_bad     = (num_groups == '0) || (num_groups > MAX_GROUPS);

    // busy is low in both IDLE and DONE, so a start is accepted in either.
    assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            groups_r       <= '0;
            beat_cnt       <= '0;
            s_axis_tready  <= 1'b0;
            store_clr      <= 1'b0;
            wr_en          <= 1'b0;
            wr_data        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            loaded_groups  <= '0;
            err_cfg        <= 1'b0;
            err_early_last <= 1'b0;
            err_no_last    <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            done      <= 1'b0;
            store_clr <= 1'b0;
            wr_en     <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start_ok) begin
                        err_cfg        <= cfg_bad;
                        err_early_last <= 1'b0;
                        err_no_last    <= 1'b0;
                        if (cfg_bad) begin
                            // Rejected load still completes so the controller
                            // never waits forever on a bad configuration.
                            done          <= 1'b1;
                            loaded_groups <= '0;
                        end else begin
                            groups_r  <= num_groups;
                            beat_cnt  <= '0;
                            store_clr <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_CLEAR;
                        end
                    end
                end

                S_CLEAR: begin
                    s_axis_tready <= 1'b1;
                    state         <= S_LOAD;
                end

                S_LOAD: begin
                    if (handshake) begin
                        wr_en    <= 1'b1;
                        wr_data  <= s_axis_tdata;
                        beat_cnt <= beat_next;
                        if (final_beat) begin
                            err_no_last   <= ~s_axis_tlast;
                            s_axis_tready <= 1'b0;
                            state         <= S_FLUSH;
                        end else if (s_axis_tlast) begin
                            // Short frame: the beat is written, load ends here.
                            err_early_last <= 1'b1;
                            s_axis_tready  <= 1'b0;
                            state          <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    // An odd trailing beat is written but not counted as a group.
                    loaded_groups <= beat_cnt[CNT_WIDTH-1:1];
                    state         <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BIAS_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum + s_axis_tdata[31:0] + s_axis_tdata[63:32]
                                 + s_axis_tdata[95:64] + s_axis_tdata[127:96];
        end
    end
`endif

endmodule
